// File: rtl/axi_lite_cmd_master_if.sv
// axi_lite_cmd_master_if: AXI4-Lite bus between the command master and its slave
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR;
  logic                    M_AXI_AWVALID;
  logic                    M_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB;
  logic                    M_AXI_WVALID;
  logic                    M_AXI_WREADY;
  logic [1:0]              M_AXI_BRESP;
  logic                    M_AXI_BVALID;
  logic                    M_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR;
  logic                    M_AXI_ARVALID;
  logic                    M_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   M_AXI_RDATA;
  logic [1:0]              M_AXI_RRESP;
  logic                    M_AXI_RVALID;
  logic                    M_AXI_RREADY;
  modport master (
    output M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID,
           M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// axi_lite_cmd_master: command stream to AXI4-Lite master with per-phase timeout and stats
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH     = 12,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    busy,
  axi_lite_cmd_master_if.master   m_axi,
  output logic [CNT_WIDTH-1:0]    wr_count,
  output logic [CNT_WIDTH-1:0]    rd_count,
  output logic [CNT_WIDTH-1:0]    err_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RESP} state_t;
  state_t                  state_q, state_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d, is_wr_q, is_wr_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [1:0]              resp_q, resp_d;
  logic                    tout_q, tout_d, abort, expired;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [CNT_WIDTH-1:0]    wr_q, wr_d, rd_q, rd_d, err_q, err_d;
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return c + CNT_WIDTH'(~&c);
  endfunction
  assign expired   = tmo_q == TW'(TIMEOUT_CYCLES - 1);
  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;
  assign rsp_timeout = tout_q;
  assign wr_count  = wr_q;
  assign rd_count  = rd_q;
  assign err_count = err_q;
  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = wstrb_q;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = araddr_q;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;
  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    is_wr_d   = is_wr_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    tout_d    = tout_q;
    tmo_d     = tmo_q + TW'(1);
    wr_d      = wr_q;
    rd_d      = rd_q;
    err_d     = err_q;
    abort     = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid) begin
        is_wr_d = cmd_write;
        tmo_d   = '0;
        if (cmd_write) begin
          state_d   = WR;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          awaddr_d  = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
        end else begin
          state_d   = RD_ADDR;
          arvalid_d = 1'b1;
          araddr_d  = cmd_addr;
        end
      end
      // a phase is done once its VALID has been withdrawn after the handshake
      WR: begin
        awvalid_d = awvalid_q & ~m_axi.M_AXI_AWREADY;
        wvalid_d  = wvalid_q & ~m_axi.M_AXI_WREADY;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
          tmo_d    = '0;
        end else abort = expired;
      end
      WR_RESP: if (m_axi.M_AXI_BVALID) begin
        state_d  = RESP;
        bready_d = 1'b0;
        resp_d   = m_axi.M_AXI_BRESP;
        rdata_d  = '0;
        tout_d   = 1'b0;
      end else abort = expired;
      RD_ADDR: if (m_axi.M_AXI_ARREADY) begin
        state_d   = RD_DATA;
        arvalid_d = 1'b0;
        rready_d  = 1'b1;
        tmo_d     = '0;
      end else abort = expired;
      RD_DATA: if (m_axi.M_AXI_RVALID) begin
        state_d  = RESP;
        rready_d = 1'b0;
        resp_d   = m_axi.M_AXI_RRESP;
        rdata_d  = m_axi.M_AXI_RDATA;
        tout_d   = 1'b0;
      end else abort = expired;
      RESP: if (rsp_ready) begin
        state_d = IDLE;
        wr_d    = (is_wr_q && !tout_q) ? sat_inc(wr_q) : wr_q;
        rd_d    = (!is_wr_q && !tout_q) ? sat_inc(rd_q) : rd_q;
        err_d   = (resp_q != 2'b00 || tout_q) ? sat_inc(err_q) : err_q;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = RESP;
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      rdata_d   = '0;
      resp_d    = 2'b11;
      tout_d    = 1'b1;
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      is_wr_q   <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      tout_q    <= 1'b0;
      tmo_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      is_wr_q   <= is_wr_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      tout_q    <= tout_d;
      tmo_q     <= tmo_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      err_q     <= err_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb_axi_lite_cmd_master: table-driven and randomized checks against a latency/response model
module tb_axi_lite_cmd_master;
  localparam int AW = 12, DW = 32, TO = 16, CW = 16;
  logic ACLK = 1'b0, ARESET = 1'b1;
  always #5 ACLK = ~ACLK;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [DW/8-1:0] cmd_wstrb = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_timeout, busy;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic [CW-1:0] wr_count, rd_count, err_count;
  axi_lite_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  axi_lite_cmd_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .busy(busy), .m_axi(bus),
    .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
  );
  // slave: each phase answers after a configured number of cycles
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] bresp_c = '0, rresp_c = '0;
  logic [DW-1:0] rdata_c = '0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, awv_n, wv_n, arv_n, b_hs;
  logic aw_got, w_got, ar_got;
  logic [AW-1:0] awaddr_s, araddr_s;
  logic [DW-1:0] wdata_s;
  logic [DW/8-1:0] wstrb_s;
  assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_cnt >= aw_dly);
  assign bus.M_AXI_WREADY  = bus.M_AXI_WVALID && (w_cnt >= w_dly);
  assign bus.M_AXI_BVALID  = aw_got && w_got && (b_cnt >= b_dly);
  assign bus.M_AXI_BRESP   = bresp_c;
  assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID && (ar_cnt >= ar_dly);
  assign bus.M_AXI_RVALID  = ar_got && (r_cnt >= r_dly);
  assign bus.M_AXI_RDATA   = rdata_c;
  assign bus.M_AXI_RRESP   = rresp_c;
  always @(posedge ACLK) begin
    if (ARESET || (cmd_valid && cmd_ready)) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      awv_n <= 0; wv_n <= 0; arv_n <= 0; b_hs <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      awaddr_s <= '0; araddr_s <= '0; wdata_s <= '0; wstrb_s <= '0;
    end else begin
      if (bus.M_AXI_AWVALID) begin awv_n <= awv_n + 1; aw_cnt <= aw_cnt + 1; end
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin aw_got <= 1'b1; awaddr_s <= bus.M_AXI_AWADDR; end
      if (bus.M_AXI_WVALID) begin wv_n <= wv_n + 1; w_cnt <= w_cnt + 1; end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        w_got <= 1'b1; wdata_s <= bus.M_AXI_WDATA; wstrb_s <= bus.M_AXI_WSTRB;
      end
      if (aw_got && w_got) b_cnt <= b_cnt + 1;
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) begin b_hs <= b_hs + 1; aw_got <= 1'b0; w_got <= 1'b0; end
      if (bus.M_AXI_ARVALID) begin arv_n <= arv_n + 1; ar_cnt <= ar_cnt + 1; end
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin ar_got <= 1'b1; araddr_s <= bus.M_AXI_ARADDR; end
      if (ar_got) r_cnt <= r_cnt + 1;
      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) ar_got <= 1'b0;
    end
  end
  // d0/d1/d2 = AW/W/B delays for writes, AR/R delays for reads
  typedef struct {
    logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; logic [DW/8-1:0] strb;
    int d0; int d1; int d2; logic [1:0] resp; int hold; logic pend;
    logic [1:0] e_resp; logic [DW-1:0] e_rdata; logic e_to; int e_lat;
  } vec_t;
  int n_chk = 0, n_err = 0;
  int m_wr = 0, m_rd = 0, m_err = 0;
  vec_t vt[$];
  int n;
  function automatic vec_t mk(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [DW/8-1:0] strb, input int d0, d1, d2, input logic [1:0] resp,
                              input int hold, input logic pend, input logic [1:0] e_resp,
                              input logic [DW-1:0] e_rdata, input logic e_to, input int e_lat);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.strb = strb; v.d0 = d0; v.d1 = d1; v.d2 = d2;
    v.resp = resp; v.hold = hold; v.pend = pend; v.e_resp = e_resp; v.e_rdata = e_rdata;
    v.e_to = e_to; v.e_lat = e_lat;
    return v;
  endfunction
  // response and accept-to-rsp_valid latency from the per-phase timing rules
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int p1 = v.wr ? ((v.d0 > v.d1) ? v.d0 : v.d1) : v.d0;
    int p2 = v.wr ? v.d2 : v.d1;
    r.e_to = (p1 >= TO) || (p2 >= TO);
    r.e_lat = (p1 >= TO) ? 1 + TO : (p2 >= TO) ? 2 + p1 + TO : 3 + p1 + p2;
    r.e_resp = r.e_to ? 2'b11 : v.resp;
    r.e_rdata = (r.e_to || v.wr) ? '0 : v.data;
    return r;
  endfunction
  function automatic int vcyc(input int d);
    return (d + 1 < TO) ? d + 1 : TO;
  endfunction
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_BREADY, bus.M_AXI_ARVALID,
        bus.M_AXI_RREADY, rsp_valid, rsp_timeout, busy, rsp_resp}), 64'(0));
    chk({tag, "_addr"}, 64'({bus.M_AXI_AWADDR, bus.M_AXI_ARADDR, bus.M_AXI_WSTRB}), 64'(0));
    chk({tag, "_data"}, 64'({bus.M_AXI_WDATA, rsp_rdata}), 64'(0));
    chk({tag, "_cnt"}, 64'({wr_count, rd_count, err_count}), 64'(0));
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
  endtask
  // caller is at a falling edge; returns at a falling edge with the DUT back in IDLE
  task automatic run(input vec_t v);
    int k, lat;
    logic [DW-1:0] rd0;
    logic [1:0] rs0;
    logic to0;
    aw_dly = v.d0; w_dly = v.d1; b_dly = v.d2; bresp_c = v.resp;
    ar_dly = v.d0; r_dly = v.d1; rresp_c = v.resp; rdata_c = v.data;
    cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.data; cmd_wstrb = v.strb; cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge ACLK); k++; end
    chk("accept_wait", 64'(k), 64'(0));
    @(posedge ACLK);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge ACLK); lat++; end
    chk("rsp_latency", 64'(lat), 64'(v.e_lat));
    chk("rsp_resp", 64'(rsp_resp), 64'(v.e_resp));
    chk("rsp_rdata", 64'(rsp_rdata), 64'(v.e_rdata));
    chk("rsp_timeout", 64'(rsp_timeout), 64'(v.e_to));
    chk("awvalid_cycles", 64'(awv_n), 64'(v.wr ? vcyc(v.d0) : 0));
    chk("wvalid_cycles", 64'(wv_n), 64'(v.wr ? vcyc(v.d1) : 0));
    chk("arvalid_cycles", 64'(arv_n), 64'(v.wr ? 0 : vcyc(v.d0)));
    chk("b_handshakes", 64'(b_hs), 64'((v.wr && !v.e_to) ? 1 : 0));
    if (v.wr && v.d0 < TO) chk("awaddr", 64'(awaddr_s), 64'(v.addr));
    if (v.wr && v.d1 < TO) chk("wdata_wstrb", 64'({wdata_s, wstrb_s}), 64'({v.data, v.strb}));
    if (!v.wr && v.d0 < TO) chk("araddr", 64'(araddr_s), 64'(v.addr));
    rd0 = v.e_rdata; rs0 = v.e_resp; to0 = v.e_to;
    for (int i = 0; i < v.hold; i++) begin
      if (v.pend) cmd_valid = 1'b1;
      @(negedge ACLK);
      chk("rsp_hold", 64'({rsp_valid, rsp_resp, rsp_rdata, rsp_timeout}), 64'({1'b1, rs0, rd0, to0}));
      chk("hold_cmd_ready", 64'(cmd_ready), 64'(0));
    end
    rsp_ready = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    rsp_ready = 1'b0;
    if (!v.e_to) begin if (v.wr) m_wr++; else m_rd++; end
    if (v.e_to || v.e_resp != 2'b00) m_err++;
    chk("post_idle", 64'({cmd_ready, busy, rsp_valid}), 64'({1'b1, 1'b0, 1'b0}));
    chk("counters", 64'({wr_count, rd_count, err_count}), 64'({CW'(m_wr), CW'(m_rd), CW'(m_err)}));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end
  initial begin
    vt.push_back(mk(1, 'h000, 'h0000_0001, 'hF, 0, 0, 0, 2'b00, 0, 0, 2'b00, '0, 0, 3));
    vt.push_back(mk(0, 'h004, 'h0000_0005, 'h0, 2, 0, 0, 2'b00, 0, 0, 2'b00, 'h5, 0, 5));
    vt.push_back(mk(1, 'h008, 'hA5A5_0F0F, 'h3, 3, 0, 0, 2'b10, 0, 0, 2'b10, '0, 0, 6));
    vt.push_back(mk(0, 'h00C, 'h0000_0077, 'h0, 99, 0, 0, 2'b00, 0, 0, 2'b11, '0, 1, 17));
    vt.push_back(mk(1, 'h010, 'h0000_1234, 'hF, 0, 0, 1, 2'b00, 5, 1, 2'b00, '0, 0, 4));
    vt.push_back(mk(0, 'h014, 'hDEAD_BEEF, 'h0, 0, 3, 0, 2'b01, 0, 0, 2'b01, 'hDEAD_BEEF, 0, 6));
    vt.push_back(mk(1, 'h018, 'h0000_0055, 'hF, 0, 0, 16, 2'b00, 0, 0, 2'b11, '0, 1, 18));
    vt.push_back(mk(1, 'h01C, 'h0000_0066, 'hF, 15, 2, 0, 2'b00, 0, 0, 2'b00, '0, 0, 18));
    vt.push_back(mk(1, 'h020, 'h0000_0077, 'hF, 0, 16, 0, 2'b00, 1, 0, 2'b11, '0, 1, 17));
    vt.push_back(mk(0, 'h024, 'h0000_0088, 'h0, 0, 15, 0, 2'b11, 0, 0, 2'b11, 'h88, 0, 18));
    vt.push_back(mk(0, 'h028, 'h0000_0099, 'h0, 1, 16, 0, 2'b00, 0, 0, 2'b11, '0, 1, 19));
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    check_reset("reset");
    ARESET = 1'b0;
    foreach (vt[i]) run(vt[i]);
    aw_dly = 0; w_dly = 0; b_dly = 8; bresp_c = 2'b00;
    cmd_write = 1'b1; cmd_addr = 'h030; cmd_wdata = 'h1; cmd_wstrb = 'hF; cmd_valid = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    cmd_valid = 1'b0;
    n = 0;
    while (!bus.M_AXI_BREADY && n < 20) begin @(negedge ACLK); n++; end
    chk("reach_wr_resp", 64'({bus.M_AXI_BREADY, busy}), 64'({1'b1, 1'b1}));
    ARESET = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    check_reset("mid_reset");
    ARESET = 1'b0;
    m_wr = 0; m_rd = 0; m_err = 0;
    run(mk(1, 'h000, 'h0000_CAFE, 'hF, 1, 0, 0, 2'b00, 0, 0, 2'b00, '0, 0, 4));
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int d[3];
      for (int j = 0; j < 3; j++)
        d[j] = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
      v = mk(1'($urandom_range(0, 1)), AW'($urandom) & AW'('hFFC), $urandom, 4'($urandom),
             d[0], d[1], d[2], 2'($urandom), int'($urandom_range(0, 2)), 0, 2'b00, '0, 0, 0);
      run(model(v));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
